sysid_checker: RTL and testbench
================================

# sysid_checker

Avalon-MM read master that sits opposite the system-ID slave on the control bus. On a start pulse it reads word 0 (system ID) and word 1 (build timestamp), compares each against compile-time expected values, and reports pass/fail to boot/supervisor logic. Each access has a bounded wait, so a missing or hung slave is reported as a timeout instead of stalling.

## Interface
Parameters:
- EXPECTED_ID, 32'd2128810887, ID value required at address 0
- EXPECTED_TS, 32'd1554115690, timestamp value required at address 1
- TIMEOUT_CYCLES, 255, maximum waitrequest-high cycles per access (1..65535)

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run a check; ignored while busy
- avm_address  out  1  word address: 0 = ID, 1 = timestamp
- avm_read  out  1  read strobe, held until waitrequest low
- avm_readdata  in  32  read data, valid in the cycle avm_read=1 and avm_waitrequest=0
- avm_waitrequest  in  1  slave stall
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when results are final
- pass  out  1  id_ok & ts_ok & !timeout
- id_ok  out  1  captured ID == EXPECTED_ID
- ts_ok  out  1  captured timestamp == EXPECTED_TS
- timeout  out  1  an access exceeded TIMEOUT_CYCLES
- id_value  out  32  last captured ID
- ts_value  out  32  last captured timestamp

## Operation
- States: IDLE, RD_ID, RD_TS, FIN.
- IDLE: busy=0. start=1 → RD_ID; clear id_ok, ts_ok, pass, timeout, wait counter.
- RD_ID: avm_read=1, avm_address=0. waitrequest=0 → capture avm_readdata into id_value, set id_ok on match, clear counter → RD_TS.
- RD_TS: avm_read=1, avm_address=1. waitrequest=0 → capture into ts_value, set ts_ok on match → FIN.
- In RD_ID/RD_TS with waitrequest=1: counter increments; when counter reaches TIMEOUT_CYCLES-1 while still stalled → timeout=1, no capture, → FIN (remaining access skipped).
- FIN: done=1 for exactly one cycle, pass computed → IDLE.
- Result flags and values hold until the next accepted start.
- start while busy or in FIN: ignored, no queuing.
- Comparison is a full 32-bit equality; no masking.
- Counter width is 16 bits; TIMEOUT_CYCLES=1 times out on the first stalled cycle.

## Timing
- All outputs registered. Reset values: avm_read=0, avm_address=0, busy=0, done=0, pass=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0, state=IDLE.
- start sampled at edge N → avm_read=1, busy=1 from cycle N+1.
- Zero-wait slave: ID read in cycle N+1, timestamp read in N+2, done=1 and results valid in N+3. That is the minimum latency of 3 cycles.
- Each waitrequest-high cycle adds one cycle.
- avm_address/avm_read stay stable while waitrequest=1.
- Reset asserted mid-check: at the next edge all outputs return to reset values and no done pulse is emitted. An in-flight read is dropped without completion.

## Configuration
- SYSID_CHECK_TS_EN defined: behaviour as above.
- Undefined: RD_TS is never entered. RD_ID success → FIN directly, giving a minimum latency of 2 cycles. ts_ok is forced to 1 on every accepted start, ts_value stays 0, and address 1 is never driven.

## Structure
- Package sysid_checker_pkg: state enum (IDLE, RD_ID, RD_TS, FIN), ADDR_ID=1'b0, ADDR_TS=1'b1, default expected-value constants, counter width constant (16).
- One sub-module: sysid_access_timer, a loadable wait counter with clear, enable and expired output, instantiated once.

## Test plan
- Zero-wait slave returning 2128810887 / 1554115690; start pulse → done exactly 3 cycles later, pass=1, id_ok=1, ts_ok=1, avm_address sequence 0,1.
- Slave returns ID 0x00000000 → done with id_ok=0, ts_ok=1, pass=0, id_value=0.
- waitrequest high 4 cycles on the ID read → done at cycle 7, pass=1, avm_address held 0 throughout the stall.
- waitrequest stuck high, TIMEOUT_CYCLES=8 → timeout=1 and done 9 cycles after start, pass=0, no read issued to address 1.
- Reset asserted during RD_TS → next cycle avm_read=0, busy=0, no done pulse. A new start then completes normally.
- Second start pulse while busy → ignored, exactly one done pulse. Without SYSID_CHECK_TS_EN: done 2 cycles after start, ts_ok=1, address 1 never driven.

Source files
------------

// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
// Timestamp read is built only with SYSID_CHECK_TS_EN.
package sysid_checker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_ID,
    RD_TS,
    FIN
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_ID = 32'd2128810887;
  localparam logic [31:0] DEF_TS = 32'd1554115690;

  localparam int CNT_W = 16;

endpackage

// File: rtl/sysid_access_timer.sv
// Per-access wait counter; expired flags the last tolerated stall cycle.
// Timestamp read is built only with SYSID_CHECK_TS_EN.
module sysid_access_timer
  import sysid_checker_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM reader that verifies system ID and build timestamp.
// Timestamp read is built only with SYSID_CHECK_TS_EN.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEF_ID,
  parameter logic [31:0] EXPECTED_TS    = DEF_TS,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

`ifdef SYSID_CHECK_TS_EN
  localparam state_t AFTER_ID = RD_TS;
  localparam logic   TS_INIT  = 1'b0;
`else
  localparam state_t AFTER_ID = FIN;
  localparam logic   TS_INIT  = 1'b1;
`endif

  state_t state, state_n;
  logic clr, en, expired;
  logic cap_id, cap_ts;
  logic id_ok_n, ts_ok_n, to_n;

  sysid_access_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (clr),
    .enable (en),
    .expired(expired)
  );

  always_comb begin
    state_n = state;
    clr     = 1'b0;
    en      = 1'b0;
    cap_id  = 1'b0;
    cap_ts  = 1'b0;
    id_ok_n = id_ok;
    ts_ok_n = ts_ok;
    to_n    = timeout;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = RD_ID;
          clr     = 1'b1;
          id_ok_n = 1'b0;
          ts_ok_n = TS_INIT;
          to_n    = 1'b0;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          cap_id  = 1'b1;
          clr     = 1'b1;
          id_ok_n = (avm_readdata == EXPECTED_ID);
          state_n = AFTER_ID;
        end else if (expired) begin
          to_n    = 1'b1;
          state_n = FIN;
        end else begin
          en = 1'b1;
        end
      end
`ifdef SYSID_CHECK_TS_EN
      RD_TS: begin
        if (!avm_waitrequest) begin
          cap_ts  = 1'b1;
          ts_ok_n = (avm_readdata == EXPECTED_TS);
          state_n = FIN;
        end else if (expired) begin
          to_n    = 1'b1;
          state_n = FIN;
        end else begin
          en = 1'b1;
        end
      end
`endif
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state       <= state_n;
      avm_read    <= (state_n == RD_ID) || (state_n == RD_TS);
      avm_address <= (state_n == RD_TS) ? ADDR_TS : ADDR_ID;
      busy        <= (state_n != IDLE);
      done        <= (state_n == FIN);
      id_ok       <= id_ok_n;
      ts_ok       <= ts_ok_n;
      timeout     <= to_n;
      // Verdict is registered together with done so both appear in one cycle.
      if (state_n == FIN) begin
        pass <= id_ok_n & ts_ok_n & ~to_n;
      end else if (state == IDLE && start) begin
        pass <= 1'b0;
      end
      if (cap_id) id_value <= avm_readdata;
      if (cap_ts) ts_value <= avm_readdata;
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Self-checking bench for sysid_checker with a stalling slave model.
// Expectations follow SYSID_CHECK_TS_EN when it is defined.
module tb_sysid_checker;

  localparam int          T   = 8;
  localparam logic [31:0] EID = 32'd2128810887;
  localparam logic [31:0] ETS = 32'd1554115690;
`ifdef SYSID_CHECK_TS_EN
  localparam bit TS = 1'b1;
`else
  localparam bit TS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  always #5 clk = ~clk;

  sysid_checker #(
    .EXPECTED_ID   (EID),
    .EXPECTED_TS   (ETS),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout        (timeout),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_id, m_ts;
  int   done_at, ndone, n_ts, addr_bad;
  logic r_pass, r_id_ok, r_ts_ok, r_to;
  logic [31:0] r_idv, r_tsv;

  int   e_lat;
  logic e_id, e_ts, e_to, e_pass;

  // Reference: latency and verdict from stall counts and returned words.
  task automatic model(input int sid, input int sts,
                       input logic [31:0] vid, input logic [31:0] vts);
    bit id_done, ts_done;
    id_done = (sid < T);
    ts_done = TS && id_done && (sts < T);
    if (!id_done)      e_lat = T + 1;
    else if (!TS)      e_lat = sid + 2;
    else if (!ts_done) e_lat = sid + 1 + T + 1;
    else               e_lat = sid + sts + 3;
    e_to   = !id_done || (TS && !ts_done);
    e_id   = id_done && (vid == EID);
    e_ts   = TS ? (ts_done && (vts == ETS)) : 1'b1;
    e_pass = e_id && e_ts && !e_to;
    if (id_done) m_id = vid;
    if (ts_done) m_ts = vts;
  endtask

  // Slave engine: pulses start, serves reads with given stalls, logs results.
  task automatic run(input int sid, input int sts,
                     input logic [31:0] vid, input logic [31:0] vts,
                     input int restart_at);
    int   left_id, left_ts;
    logic prev_stall, prev_addr;
    left_id = sid;
    left_ts = sts;
    done_at = -1;
    ndone = 0;
    n_ts = 0;
    addr_bad = 0;
    prev_stall = 1'b0;
    prev_addr = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (done_at < 0) begin
          done_at = c;
          r_pass  = pass;
          r_id_ok = id_ok;
          r_ts_ok = ts_ok;
          r_to    = timeout;
          r_idv   = id_value;
          r_tsv   = ts_value;
        end
      end
      if (avm_read && avm_address) n_ts++;
      if (avm_read && prev_stall && avm_address !== prev_addr) addr_bad++;
      avm_waitrequest = avm_read && ((avm_address ? left_ts : left_id) > 0);
      avm_readdata    = avm_address ? vts : vid;
      start           = (c == restart_at);
      prev_stall      = avm_waitrequest;
      prev_addr       = avm_address;
      @(posedge clk); #1;
      if (prev_stall) begin
        if (prev_addr) left_ts--;
        else left_id--;
      end
      if (done_at > 0 && c >= done_at + 3) break;
    end
    start = 1'b0;
    avm_waitrequest = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({avm_read, avm_address, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_bus: got %b want 0000",
               {avm_read, avm_address, busy, done});
    end
    n_checks++;
    if ({pass, id_ok, ts_ok, timeout} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {pass, id_ok, ts_ok, timeout});
    end
    n_checks++;
    if (id_value !== 32'd0 || ts_value !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: got %h/%h want 0/0", id_value, ts_value);
    end
    reset = 1'b0;
    m_id = '0;
    m_ts = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait;
    model(0, 0, EID, ETS);
    run(0, 0, EID, ETS, 0);
    n_checks++;
    if (done_at !== e_lat) begin
      n_fail++;
      $display("FAIL zw_latency: got %0d want %0d", done_at, e_lat);
    end
    n_checks++;
    if ({r_pass, r_id_ok, r_ts_ok, r_to} !== {e_pass, e_id, e_ts, e_to}) begin
      n_fail++;
      $display("FAIL zw_flags: got %b want %b", {r_pass, r_id_ok, r_ts_ok, r_to},
               {e_pass, e_id, e_ts, e_to});
    end
    n_checks++;
    if (n_ts !== (TS ? 1 : 0)) begin
      n_fail++;
      $display("FAIL zw_ts_reads: got %0d want %0d", n_ts, TS ? 1 : 0);
    end
    n_checks++;
    if (r_idv !== m_id || r_tsv !== m_ts) begin
      n_fail++;
      $display("FAIL zw_values: got %h/%h want %h/%h", r_idv, r_tsv, m_id, m_ts);
    end
  endtask

  task automatic test_bad_id;
    model(0, 0, 32'd0, ETS);
    run(0, 0, 32'd0, ETS, 0);
    n_checks++;
    if ({r_pass, r_id_ok, r_ts_ok} !== {1'b0, 1'b0, e_ts}) begin
      n_fail++;
      $display("FAIL bad_id_flags: got %b want %b", {r_pass, r_id_ok, r_ts_ok},
               {1'b0, 1'b0, e_ts});
    end
    n_checks++;
    if (r_idv !== 32'd0) begin
      n_fail++;
      $display("FAIL bad_id_value: got %h want 0", r_idv);
    end
  endtask

  task automatic test_stall;
    model(4, 0, EID, ETS);
    run(4, 0, EID, ETS, 0);
    n_checks++;
    if (done_at !== e_lat) begin
      n_fail++;
      $display("FAIL stall_latency: got %0d want %0d", done_at, e_lat);
    end
    n_checks++;
    if (r_pass !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_pass: got %b want 1", r_pass);
    end
    n_checks++;
    if (addr_bad !== 0) begin
      n_fail++;
      $display("FAIL stall_addr_stable: got %0d changes want 0", addr_bad);
    end
  endtask

  task automatic test_timeout;
    model(1000, 0, EID, ETS);
    run(1000, 0, EID, ETS, 0);
    n_checks++;
    if (done_at !== T + 1) begin
      n_fail++;
      $display("FAIL to_latency: got %0d want %0d", done_at, T + 1);
    end
    n_checks++;
    if ({r_to, r_pass} !== 2'b10) begin
      n_fail++;
      $display("FAIL to_flags: got %b want 10", {r_to, r_pass});
    end
    n_checks++;
    if (n_ts !== 0) begin
      n_fail++;
      $display("FAIL to_ts_reads: got %0d want 0", n_ts);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    avm_waitrequest = 1'b0;
    avm_readdata = EID;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (TS) begin
      @(posedge clk); #1;
      n_checks++;
      if ({avm_read, avm_address} !== 2'b11) begin
        n_fail++;
        $display("FAIL mid_in_rd_ts: got %b want 11", {avm_read, avm_address});
      end
    end
    avm_waitrequest = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    m_id = '0;
    m_ts = '0;
    n_checks++;
    if ({avm_read, busy, done} !== 3'b000 || id_value !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got %b id %h want 000 id 0",
               {avm_read, busy, done}, id_value);
    end
    seen = 0;
    repeat (5) begin
      if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL mid_no_done: got %0d pulses want 0", seen);
    end
    model(0, 0, EID, ETS);
    run(0, 0, EID, ETS, 0);
    n_checks++;
    if (done_at !== e_lat || r_pass !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_recover: got lat %0d pass %b want %0d 1",
               done_at, r_pass, e_lat);
    end
  endtask

  task automatic test_back_to_back;
    model(0, 0, EID, ETS);
    run(0, 0, EID, ETS, 1);
    n_checks++;
    if (ndone !== 1 || done_at !== e_lat) begin
      n_fail++;
      $display("FAIL b2b_busy: got %0d dones at %0d want 1 at %0d",
               ndone, done_at, e_lat);
    end
    model(2, 1, EID, ETS);
    run(2, 1, EID, ETS, e_lat);
    n_checks++;
    if (ndone !== 1 || done_at !== e_lat) begin
      n_fail++;
      $display("FAIL b2b_fin: got %0d dones at %0d want 1 at %0d",
               ndone, done_at, e_lat);
    end
  endtask

  task automatic test_random;
    int sid, sts;
    logic [31:0] vid, vts;
    for (int i = 0; i < 10; i++) begin
      sid = ($urandom_range(0, 3) == 0) ? 1000 : int'($urandom_range(0, 5));
      sts = ($urandom_range(0, 3) == 0) ? 1000 : int'($urandom_range(0, 5));
      vid = EID;
      vts = ETS;
      if ($urandom_range(0, 2) == 0) vid = vid ^ (32'd1 << $urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) vts = vts ^ (32'd1 << $urandom_range(0, 31));
      model(sid, sts, vid, vts);
      run(sid, sts, vid, vts, 0);
      n_checks++;
      if (done_at !== e_lat || ndone !== 1) begin
        n_fail++;
        $display("FAIL rnd%0d_latency: got %0d (%0d dones) want %0d",
                 i, done_at, ndone, e_lat);
      end
      n_checks++;
      if ({r_pass, r_id_ok, r_ts_ok, r_to} !== {e_pass, e_id, e_ts, e_to}) begin
        n_fail++;
        $display("FAIL rnd%0d_flags: got %b want %b", i,
                 {r_pass, r_id_ok, r_ts_ok, r_to}, {e_pass, e_id, e_ts, e_to});
      end
      n_checks++;
      if (r_idv !== m_id || r_tsv !== m_ts) begin
        n_fail++;
        $display("FAIL rnd%0d_values: got %h/%h want %h/%h",
                 i, r_idv, r_tsv, m_id, m_ts);
      end
      n_checks++;
      if (addr_bad !== 0 || (!TS && n_ts !== 0)) begin
        n_fail++;
        $display("FAIL rnd%0d_bus: got %0d changes %0d ts reads want 0",
                 i, addr_bad, n_ts);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_bad_id();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
